// File: rtl/display_pkg.sv
// Shared constants, blink encoding and digit helpers for the 4-digit display path.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned SEL_W      = 2;
  localparam int unsigned DIGITS_W   = NUM_DIGITS * BCD_W;

  localparam logic [SEL_W-1:0] DIGIT_LEFT  = 2'd0;
  localparam logic [SEL_W-1:0] DIGIT_RIGHT = 2'd3;

  typedef enum logic {
    BLINK_ON  = 1'b0,
    BLINK_OFF = 1'b1
  } blink_phase_t;

  // Digit 0 sits in the top nibble; digit 3 in the bottom nibble.
  function automatic logic [BCD_W-1:0] digit_nibble(input logic [DIGITS_W-1:0] d,
                                                    input logic [SEL_W-1:0]    sel);
    logic [BCD_W-1:0] n;
    case (sel)
      2'd0:    n = d[3*BCD_W +: BCD_W];
      2'd1:    n = d[2*BCD_W +: BCD_W];
      2'd2:    n = d[1*BCD_W +: BCD_W];
      default: n = d[0 +: BCD_W];
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Generic prescaler: tick is high for one cycle out of every DIV cycles.
module tick_divider #(
  parameter int unsigned DIV = 250000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] count;

  assign tick = (count == CNT_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/display_scan_mux.sv
// Scans four BCD digits onto the shared decoder with per-frame snapshot,
// per-digit blink, whole-display blanking and active-low decimal points.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 250000,
  parameter int unsigned BLINK_FRAMES = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS_W-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  input  logic                  blank,
  output logic                  en,
  output logic [SEL_W-1:0]      en_2,
  output logic [BCD_W-1:0]      num,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int unsigned FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic                tick;
  logic                wrap;
  logic [SEL_W-1:0]    en_2_next;
  logic [BCD_W-1:0]    num_next;
  logic [DIGITS_W-1:0] snapshot, snapshot_next;
  logic [FRAME_W-1:0]  frame_cnt, frame_cnt_next;
  blink_phase_t        phase, phase_next;
  logic                en_next;
  logic                dp_next;

  tick_divider #(.DIV(REFRESH_DIV)) u_refresh_div (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Next-state for scan position, snapshot, blink phase and output pins.
  always_comb begin
    en_2_next      = en_2;
    num_next       = num;
    snapshot_next  = snapshot;
    frame_cnt_next = frame_cnt;
    phase_next     = phase;
    wrap           = tick && (en_2 == DIGIT_RIGHT);

    if (tick) begin
      en_2_next = en_2 + SEL_W'(1);
      num_next  = digit_nibble(snapshot, en_2_next);
    end

    // Frame boundary: fresh snapshot, digit 0 bypasses it, blink bookkeeping.
    if (wrap) begin
      snapshot_next = digits_in;
      num_next      = digit_nibble(digits_in, DIGIT_LEFT);
      if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_next = '0;
        phase_next     = (phase == BLINK_ON) ? BLINK_OFF : BLINK_ON;
      end else begin
        frame_cnt_next = frame_cnt + FRAME_W'(1);
      end
    end

    en_next = ~blank & ~(blink_mask[DIGIT_RIGHT - en_2_next] & (phase_next == BLINK_OFF));
    dp_next = ~(en_next & dp_mask[DIGIT_RIGHT - en_2_next]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_2        <= DIGIT_LEFT;
      num         <= digit_nibble(digits_in, DIGIT_LEFT);
      snapshot    <= '0;
      frame_cnt   <= '0;
      phase       <= BLINK_ON;
      en          <= 1'b0;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      en_2        <= en_2_next;
      num         <= num_next;
      snapshot    <= snapshot_next;
      frame_cnt   <= frame_cnt_next;
      phase       <= phase_next;
      en          <= en_next;
      dp          <= dp_next;
      frame_start <= wrap;
    end
  end

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux: slot-by-slot vector table plus reset and divide-by-1 sequences.
module tb_display_scan_mux;

  logic        clk = 1'b0;
  logic        rst, rst1;
  logic [15:0] digits_in, digits_in1;
  logic [3:0]  blink_mask, dp_mask, blink_mask1, dp_mask1;
  logic        blank, blank1;
  logic        en, dp, frame_start, en1, dp1, frame_start1;
  logic [1:0]  en_2, en_2_1;
  logic [3:0]  num, num1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  display_scan_mux #(.REFRESH_DIV(4), .BLINK_FRAMES(2)) u_dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .blink_mask(blink_mask),
    .dp_mask(dp_mask), .blank(blank), .en(en), .en_2(en_2), .num(num),
    .dp(dp), .frame_start(frame_start)
  );

  display_scan_mux #(.REFRESH_DIV(1), .BLINK_FRAMES(2)) u_dut_div1 (
    .clk(clk), .rst(rst1), .digits_in(digits_in1), .blink_mask(blink_mask1),
    .dp_mask(dp_mask1), .blank(blank1), .en(en1), .en_2(en_2_1), .num(num1),
    .dp(dp1), .frame_start(frame_start1)
  );

  typedef struct {
    int         steps;
    logic [15:0] digits;
    logic [3:0]  bmask;
    logic [3:0]  dmask;
    logic        blk;
    logic [1:0]  e_en_2;
    logic [3:0]  e_num;
    logic        e_en;
    logic        e_dp;
    logic        e_fs;
  } vec_t;

  vec_t vecs[$];

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Packed as {en_2, num, en, dp, frame_start}.
  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got en_2=%0d num=%h en=%b dp=%b fs=%b, expected en_2=%0d num=%h en=%b dp=%b fs=%b",
               name, act[8:7], act[6:3], act[2], act[1], act[0],
               exp[8:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic add(input int s, input logic [15:0] d, input logic [3:0] bm, input logic [3:0] dm,
                     input logic b, input logic [1:0] e2, input logic [3:0] n,
                     input logic e, input logic p, input logic f);
    vec_t v;
    v.steps = s; v.digits = d; v.bmask = bm; v.dmask = dm; v.blk = b;
    v.e_en_2 = e2; v.e_num = n; v.e_en = e; v.e_dp = p; v.e_fs = f;
    vecs.push_back(v);
  endtask

  logic [3:0] div1_num[8];

  initial begin
    // Edge numbers in notes count rising edges after reset release.
    // Scan/snapshot: the first frame after reset reads digits 1..3 from the cleared snapshot.
    add(4, 16'h1234, 4'h0, 4'h0, 0, 2, 4'h0, 1, 1, 0);  // e8
    add(4, 16'h1234, 4'h0, 4'h0, 0, 3, 4'h0, 1, 1, 0);  // e12
    add(4, 16'h1234, 4'h0, 4'h0, 0, 0, 4'h1, 1, 1, 1);  // e16 wrap
    add(1, 16'h1234, 4'h0, 4'h0, 0, 0, 4'h1, 1, 1, 0);  // e17 pulse gone
    add(3, 16'h1234, 4'h0, 4'h0, 0, 1, 4'h2, 1, 1, 0);
    add(4, 16'h1234, 4'h0, 4'h0, 0, 2, 4'h3, 1, 1, 0);
    add(4, 16'h1234, 4'h0, 4'h0, 0, 3, 4'h4, 1, 1, 0);
    add(4, 16'h1234, 4'h0, 4'h0, 0, 0, 4'h1, 1, 1, 1);  // e32, phase -> OFF
    add(4, 16'h1234, 4'h0, 4'h0, 0, 1, 4'h2, 1, 1, 0);
    add(4, 16'h5678, 4'h0, 4'h0, 0, 2, 4'h3, 1, 1, 0);  // mid-frame change hidden
    add(4, 16'h5678, 4'h0, 4'h0, 0, 3, 4'h4, 1, 1, 0);
    add(4, 16'h5678, 4'h0, 4'h0, 0, 0, 4'h5, 1, 1, 1);  // e48
    add(4, 16'h5678, 4'h0, 4'h0, 0, 1, 4'h6, 1, 1, 0);
    add(4, 16'h5678, 4'h0, 4'h0, 0, 2, 4'h7, 1, 1, 0);
    add(4, 16'h5678, 4'h0, 4'h0, 0, 3, 4'h8, 1, 1, 0);
    // Blink digits 0/1; e64 toggles back to ON on the same wrap edge.
    add(4, 16'h5678, 4'hC, 4'h0, 0, 0, 4'h5, 1, 1, 1);
    add(4, 16'h5678, 4'hC, 4'h0, 0, 1, 4'h6, 1, 1, 0);
    add(4, 16'h5678, 4'hC, 4'h0, 0, 2, 4'h7, 1, 1, 0);
    add(4, 16'h5678, 4'hC, 4'h0, 0, 3, 4'h8, 1, 1, 0);
    add(4, 16'h5678, 4'hC, 4'h0, 0, 0, 4'h5, 1, 1, 1);  // e80
    add(4, 16'h5678, 4'hC, 4'h0, 0, 1, 4'h6, 1, 1, 0);
    add(4, 16'h5678, 4'hC, 4'h0, 0, 2, 4'h7, 1, 1, 0);
    add(4, 16'h5678, 4'hC, 4'h0, 0, 3, 4'h8, 1, 1, 0);
    add(4, 16'h5678, 4'hC, 4'h0, 0, 0, 4'h5, 0, 1, 1);  // e96 toggles OFF, digit 0 dark at once
    add(4, 16'h5678, 4'hC, 4'h0, 0, 1, 4'h6, 0, 1, 0);
    add(4, 16'h5678, 4'hC, 4'h0, 0, 2, 4'h7, 1, 1, 0);
    add(4, 16'h5678, 4'hC, 4'h0, 0, 3, 4'h8, 1, 1, 0);
    add(4, 16'h5678, 4'hC, 4'h0, 0, 0, 4'h5, 0, 1, 1);  // e112
    add(4, 16'h5678, 4'hC, 4'h0, 0, 1, 4'h6, 0, 1, 0);
    add(4, 16'h5678, 4'hC, 4'h0, 0, 2, 4'h7, 1, 1, 0);
    add(4, 16'h5678, 4'hC, 4'h0, 0, 3, 4'h8, 1, 1, 0);
    add(4, 16'h5678, 4'hC, 4'h0, 0, 0, 4'h5, 1, 1, 1);  // e128 ON again
    add(4, 16'h5678, 4'hC, 4'h0, 0, 1, 4'h6, 1, 1, 0);
    // Decimal point on digit 1, then blank mid-slot.
    add(4, 16'h5678, 4'h0, 4'h4, 0, 2, 4'h7, 1, 1, 0);
    add(4, 16'h5678, 4'h0, 4'h4, 0, 3, 4'h8, 1, 1, 0);
    add(4, 16'h5678, 4'h0, 4'h4, 0, 0, 4'h5, 1, 1, 1);  // e144
    add(4, 16'h5678, 4'h0, 4'h4, 0, 1, 4'h6, 1, 0, 0);  // dp lit
    add(2, 16'h5678, 4'h0, 4'h4, 0, 1, 4'h6, 1, 0, 0);
    add(1, 16'h5678, 4'h0, 4'h4, 1, 1, 4'h6, 0, 1, 0);  // blank next edge, no tick needed
    add(1, 16'h5678, 4'h0, 4'h4, 1, 2, 4'h7, 0, 1, 0);  // scanning continues
    add(4, 16'h5678, 4'h0, 4'h4, 1, 3, 4'h8, 0, 1, 0);
    add(4, 16'h5678, 4'h0, 4'h4, 0, 0, 4'h5, 1, 1, 1);  // e160, phase -> OFF

    div1_num = '{4'h0, 4'h0, 4'h0, 4'h9, 4'hA, 4'hB, 4'hC, 4'h9};

    rst = 1'b1; digits_in = 16'h1234; blink_mask = 4'h0; dp_mask = 4'h0; blank = 1'b0;
    rst1 = 1'b1; digits_in1 = 16'h9ABC; blink_mask1 = 4'h0; dp_mask1 = 4'h0; blank1 = 1'b0;

    step(2);
    check("reset_state", {en_2, num, en, dp, frame_start}, {2'd0, 4'h1, 1'b1 ^ 1'b1, 1'b1, 1'b0});
    rst = 1'b0;
    step(1);
    check("first_slot", {en_2, num, en, dp, frame_start}, {2'd0, 4'h1, 1'b1, 1'b1, 1'b0});
    step(2);
    check("no_early_tick", {en_2, num, en, dp, frame_start}, {2'd0, 4'h1, 1'b1, 1'b1, 1'b0});
    step(1);
    check("first_tick", {en_2, num, en, dp, frame_start}, {2'd1, 4'h0, 1'b1, 1'b1, 1'b0});

    foreach (vecs[i]) begin
      digits_in  = vecs[i].digits;
      blink_mask = vecs[i].bmask;
      dp_mask    = vecs[i].dmask;
      blank      = vecs[i].blk;
      step(vecs[i].steps);
      check($sformatf("vec%0d", i), {en_2, num, en, dp, frame_start},
            {vecs[i].e_en_2, vecs[i].e_num, vecs[i].e_en, vecs[i].e_dp, vecs[i].e_fs});
    end

    // Reset mid-scan at digit 2 with the blink phase OFF.
    step(8);
    check("pre_reset_slot2", {en_2, num, en, dp, frame_start}, {2'd2, 4'h7, 1'b1, 1'b1, 1'b0});
    step(1);
    rst = 1'b1; blink_mask = 4'h8;
    step(1);
    check("mid_scan_reset", {en_2, num, en, dp, frame_start}, {2'd0, 4'h5, 1'b0, 1'b1, 1'b0});
    rst = 1'b0;
    step(1);
    check("post_reset_blink_on", {en_2, num, en, dp, frame_start}, {2'd0, 4'h5, 1'b1, 1'b1, 1'b0});
    step(2);
    check("post_reset_hold", {en_2, num, en, dp, frame_start}, {2'd0, 4'h5, 1'b1, 1'b1, 1'b0});
    step(1);
    check("post_reset_tick", {en_2, num, en, dp, frame_start}, {2'd1, 4'h0, 1'b1, 1'b0, 1'b0});

    // Divide-by-1 instance: a tick on every edge.
    check("div1_reset", {en_2_1, num1, en1, dp1, frame_start1}, {2'd0, 4'h9, 1'b0, 1'b1, 1'b0});
    rst1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(1);
      check($sformatf("div1_edge%0d", k + 1), {en_2_1, num1, en1, dp1, frame_start1},
            {2'((k + 1) % 4), div1_num[k], 1'b1, 1'b1, (k == 3 || k == 7)});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
